// File: rtl/cmp_search_ctrl.sv
// Binary-search controller for a comparator-only interface. It drives successive guesses
// onto the comparator B operand and narrows [lo, hi] using the GT/EQ/LT flags until the
// hidden A value is found. Inconsistent flags or an exhausted range end the search in ERR.
module cmp_search_ctrl #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             inGT,
  input  logic             inEQ,
  input  logic             inLT,
  output logic [WIDTH-1:0] outGuess,
  output logic [WIDTH-1:0] outFound,
  output logic [3:0]       outProbes,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {StIdle, StDrive, StCheck, StDone, StErr} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] found_q, found_d;
  logic [3:0]       probes_q, probes_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mid;
  logic             flags_ok;

  // Sum is formed one bit wider so lo = hi = all-ones cannot wrap.
  assign mid = WIDTH'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);

  // Odd parity with not all three set means exactly one flag is high.
  assign flags_ok = (inGT ^ inEQ ^ inLT) & ~(inGT & inEQ & inLT);

  assign outGuess  = guess_q;
  assign outFound  = found_q;
  assign outProbes = probes_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // State and datapath registers; reset is synchronous and wins over any start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      found_q  <= '0;
      probes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      found_q  <= found_d;
      probes_q <= probes_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath updates; everything holds unless a state changes it.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    found_d  = found_q;
    probes_d = probes_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = '1;
          probes_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = StDrive;
        end
      end

      StDrive: begin
        guess_d  = mid;
        probes_d = probes_q + 4'd1;
        state_d  = StCheck;
      end

      StCheck: begin
        if (!flags_ok) begin
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = StErr;
        end else if (inEQ) begin
          found_d = guess_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (inGT) begin
          // Target above a guess already at the upper bound: range exhausted.
          if (guess_q == hi_q) begin
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = StErr;
          end else begin
            lo_d    = guess_q + WIDTH'(1);
            state_d = StDrive;
          end
        end else begin
          if (guess_q == lo_q) begin
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = StErr;
          end else begin
            hi_d    = guess_q - WIDTH'(1);
            state_d = StDrive;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/cmp_search_ctrl.md
# cmp_search_ctrl

Binary-search controller that sits on the result side of the 2-bit magnitude comparator. It drives the comparator's B operand with successive guesses and reads back the GT/EQ/LT flags. From those flags it finds the hidden value applied to operand A. It reports the found value, the number of probes taken, and an error if the flags are inconsistent. Used in the lab datapath wherever a comparator-only interface must be converted back to a binary value.

## Interface
- WIDTH, 2, operand width; legal range 2..14.
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- start  input  1  begin a search; sampled in IDLE, DONE, ERR; ignored while busy.
- inGT  input  1  comparator flag: target > outGuess.
- inEQ  input  1  comparator flag: target == outGuess.
- inLT  input  1  comparator flag: target < outGuess.
- outGuess  output  WIDTH  registered guess; drives comparator inB.
- outFound  output  WIDTH  located target value; valid while done=1.
- outProbes  output  4  number of guesses issued in the current or last search.
- busy  output  1  search in progress (DRIVE or CHECK).
- done  output  1  search succeeded; held until next start or reset.
- err  output  1  search failed; held until next start or reset.

## Operation
- Internal bounds: lo, hi are WIDTH bits. The midpoint is computed as (lo+hi)>>1 in WIDTH+1 bits, so there is no overflow at lo=hi=2^WIDTH-1.
- States and transitions:
  - IDLE: on start, set lo=0, hi=2^WIDTH-1, outProbes=0, done=0, err=0, busy=1, then go to DRIVE.
  - DRIVE: set outGuess to the midpoint and increment outProbes, then go to CHECK.
  - CHECK: sample flags. Exactly one flag must be high; otherwise go to ERR.
    - EQ: set outFound to outGuess, done=1, busy=0, then go to DONE.
    - GT: if outGuess==hi, go to ERR. Else set lo to outGuess+1 and go to DRIVE.
    - LT: if outGuess==lo, go to ERR. Else set hi to outGuess-1 and go to DRIVE.
  - DONE / ERR: outputs hold. start restarts exactly as from IDLE, on the same edge; done and err clear at that edge.
- ERR sets err=1 and busy=0. outFound keeps its previous value.
- Maximum probes is WIDTH+1; 4 bits suffices for WIDTH≤14. Hitting a bound check before EQ is the exhaustion condition and goes to ERR.
- Reset values: state IDLE, outGuess=0, outFound=0, outProbes=0, busy=0, done=0, err=0.
- reset_n low at any edge, including mid-search, forces reset values at that edge. A start sampled in the same cycle is discarded.

## Timing
- start sampled at edge k → busy=1 after k.
- First outGuess is visible after k+1. Flags are sampled at k+2.
- Each probe costs 2 cycles (DRIVE, CHECK). A search of P probes asserts done or err after edge k+2P.
- The comparator is combinational off outGuess. Flags must be settled within the CHECK cycle; the block never samples flags in DRIVE.
- In CHECK, flags are sampled only at the clock edge. Glitches between edges are irrelevant.
- start held high continuously restarts a new search the cycle after each done or err.

## Test plan
- WIDTH=2, bench comparator model with target=1. Pulse start → one probe: outGuess=1, EQ. done=1 after 2 cycles, outFound=1, outProbes=1, busy=0.
- WIDTH=2, targets 0, 2, 3 in turn:
  - target 0: guess sequence 1→0, outProbes=2.
  - target 2: guess sequence 1→2, outProbes=2.
  - target 3: guess sequence 1→2→3, outProbes=3.
  - Each ends with outFound equal to the target and err=0.
- Inconsistent flags: model drives GT=EQ=1 on the first CHECK → err=1 after 2 cycles, done=0, busy=0, outFound unchanged (0 after reset).
- Exhaustion: model forces LT at every probe with WIDTH=2. Guesses go 1→0, then LT at guess 0 (outGuess==lo) → err=1, outProbes=2.
- Reset mid-search: WIDTH=4, target=13. Drop reset_n during the second CHECK → next edge all outputs 0, state IDLE. Re-start → done with outFound=13, outProbes≤5.
- Ignored start: pulse start while busy → no restart, probe sequence unchanged. start held high after DONE → new search begins and done clears at the next edge.
